// File: rtl/data_memory_axil_pkg.sv
// Shared constants for the AXI4-Lite data memory: response codes and read-FSM states.
package data_memory_axil_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_WAIT = 2'd1;
   localparam logic [1:0] R_RESP = 2'd2;

endpackage

// File: rtl/data_memory_axil_byte_enable_ram.sv
// Word-wide RAM with a synchronous byte-masked write port and an asynchronous read port.
module byte_enable_ram #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter string       INIT_FILE   = "",
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   localparam int unsigned RAM_AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [RAM_AW-1:0]     waddr_i,
   input  logic [STRB_WIDTH-1:0] wstrb_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [RAM_AW-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < int'(STRB_WIDTH); i++) begin
            if (wstrb_i[i]) mem[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         end
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/data_memory_axil.sv
// AXI4-Lite slave data memory: byte-strobe writes, configurable read latency, SLVERR out of range.
module data_memory_axil
   import data_memory_axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 1,
   parameter string       INIT_FILE    = "",
   localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic [ADDR_WIDTH-1:0] i_AXI_AWADDR,
   input  logic                  i_AXI_AWVALID,
   output logic                  o_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0] i_AXI_WDATA,
   input  logic [STRB_WIDTH-1:0] i_AXI_WSTRB,
   input  logic                  i_AXI_WVALID,
   output logic                  o_AXI_WREADY,
   output logic [1:0]            o_AXI_BRESP,
   output logic                  o_AXI_BVALID,
   input  logic                  i_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0] i_AXI_ARADDR,
   input  logic                  i_AXI_ARVALID,
   output logic                  o_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0] o_AXI_RDATA,
   output logic [1:0]            o_AXI_RRESP,
   output logic                  o_AXI_RVALID,
   input  logic                  i_AXI_RREADY
);

   localparam int unsigned OFFS   = $clog2(STRB_WIDTH);
   localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS;
   localparam int unsigned RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("data_memory_axil: DATA_WIDTH must be 32 or 64");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
      $error("data_memory_axil: READ_LATENCY must be in 1..8");
   end

   // Byte-offset bits never select anything.
   logic unused_offs;
   assign unused_offs = ^{i_AXI_AWADDR[OFFS-1:0], i_AXI_ARADDR[OFFS-1:0]};

   // ---------------- write path ----------------
   logic                  aw_held_q, w_held_q, bvalid_q;
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;
   logic [1:0]            bresp_q;
   logic                  aw_hs, w_hs, commit, aw_in_range;
   logic [IDX_W-1:0]      aw_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;

   assign o_AXI_AWREADY = !i_Reset && !aw_held_q && !bvalid_q;
   assign o_AXI_WREADY  = !i_Reset && !w_held_q && !bvalid_q;
   assign aw_hs = o_AXI_AWREADY && i_AXI_AWVALID;
   assign w_hs  = o_AXI_WREADY && i_AXI_WVALID;

   // Bypass the holding registers so a commit can happen in the cycle both handshakes land.
   assign aw_idx  = aw_held_q ? aw_idx_q : i_AXI_AWADDR[ADDR_WIDTH-1:OFFS];
   assign wr_data = w_held_q ? w_data_q : i_AXI_WDATA;
   assign wr_strb = w_held_q ? w_strb_q : i_AXI_WSTRB;
   assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign aw_in_range = 64'(aw_idx) < 64'(DEPTH_WORDS);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= AXI_RESP_OKAY;
         aw_idx_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else if (commit) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b1;
         bresp_q   <= aw_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_idx_q  <= i_AXI_AWADDR[ADDR_WIDTH-1:OFFS];
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= i_AXI_WDATA;
            w_strb_q <= i_AXI_WSTRB;
         end
         if (bvalid_q && i_AXI_BREADY) bvalid_q <= 1'b0;
      end
   end

   assign o_AXI_BVALID = bvalid_q;
   assign o_AXI_BRESP  = bresp_q;

   // ---------------- read path ----------------
   logic [1:0]            r_state_q;
   logic [3:0]            r_cnt_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            rresp_q;
   logic [IDX_W-1:0]      ar_idx;
   logic                  ar_hs, ar_in_range;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign o_AXI_ARREADY = !i_Reset && (r_state_q == R_IDLE);
   assign ar_hs       = o_AXI_ARREADY && i_AXI_ARVALID;
   assign ar_idx      = i_AXI_ARADDR[ADDR_WIDTH-1:OFFS];
   assign ar_in_range = 64'(ar_idx) < 64'(DEPTH_WORDS);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_state_q <= R_IDLE;
         r_cnt_q   <= '0;
         rdata_q   <= '0;
         rresp_q   <= AXI_RESP_OKAY;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (ar_hs) begin
                  // Array is read before any same-edge commit lands, so reads see pre-write data.
                  rdata_q   <= ar_in_range ? ram_rdata : '0;
                  rresp_q   <= ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                  r_cnt_q   <= 4'(READ_LATENCY - 1);
                  r_state_q <= (READ_LATENCY == 1) ? R_RESP : R_WAIT;
               end
            end
            R_WAIT: begin
               if (r_cnt_q == '0) r_state_q <= R_RESP;
               else               r_cnt_q   <= r_cnt_q - 4'd1;
            end
            R_RESP: begin
               if (i_AXI_RREADY) r_state_q <= R_IDLE;
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign o_AXI_RVALID = (r_state_q == R_RESP);
   assign o_AXI_RDATA  = rdata_q;
   assign o_AXI_RRESP  = rresp_q;

   byte_enable_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_WORDS(DEPTH_WORDS),
      .INIT_FILE  (INIT_FILE)
   ) u_ram (
      .clk_i  (i_Clock),
      .we_i   (commit && aw_in_range),
      .waddr_i(aw_idx[RAM_AW-1:0]),
      .wstrb_i(wr_strb),
      .wdata_i(wr_data),
      .raddr_i(ar_idx[RAM_AW-1:0]),
      .rdata_o(ram_rdata)
   );

endmodule
